// File: rtl/mra_arbiter.sv
`default_nettype none
// ============================================================================
// mra_arbiter
//   Round-robin share of one MRA request port among NUM_REQ requesters, with
//   in-order read-response routing back to the issuing requester.
//   Revision: 1.0
// ============================================================================
module mra_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 8,
    parameter int ID_W            = $clog2(NUM_REQ),
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_rw,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         MRA_req_addr,
    output logic                          MRA_rw,
    output logic                          MRA_req_valid,
    input  logic                          MRA_ready,
    input  logic                          MRA_rsp_valid,
    input  logic [DATA_WIDTH-1:0]         MRA_rsp_data,
    output logic [CNT_W-1:0]              rd_outstanding,
    output logic                          rsp_err
);

    localparam int c_PTR_W = $clog2(MAX_OUTSTANDING);
    localparam logic [NUM_REQ-1:0] c_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_rw;
    logic                  r_valid;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [CNT_W-1:0]      r_cnt;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [ID_W-1:0]       r_fifo [MAX_OUTSTANDING];
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_err;

    logic [ADDR_WIDTH-1:0] w_addr_arr [NUM_REQ];
    logic                  w_rd_ok;
    logic [NUM_REQ-1:0]    w_eligible;
    logic                  w_found_hi;
    logic                  w_found_lo;
    logic [ID_W-1:0]       w_hi_id;
    logic [ID_W-1:0]       w_lo_id;
    logic [ID_W-1:0]       w_gnt_id;
    logic [ID_W-1:0]       w_next_ptr;
    logic                  w_gnt_rw;
    logic                  w_slot_free;
    logic                  w_do_grant;
    logic                  w_push;
    logic                  w_pop;
    logic [ID_W-1:0]       w_head;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_addr_arr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Eligibility uses the registered count, so a pop frees a read slot next cycle.
    assign w_rd_ok     = (r_cnt < CNT_W'(MAX_OUTSTANDING));
    assign w_eligible  = req_valid & (req_rw | {NUM_REQ{w_rd_ok}});
    assign w_slot_free = ~r_valid | MRA_ready;

    // Lowest eligible index at or above the pointer wins; otherwise wrap to lowest overall.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_hi_id    = '0;
        w_lo_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_lo_id    = ID_W'(i);
                w_found_lo = 1'b1;
                if (i >= int'(r_rr_ptr)) begin
                    w_hi_id    = ID_W'(i);
                    w_found_hi = 1'b1;
                end
            end
        end
    end

    assign w_gnt_id   = w_found_hi ? w_hi_id : w_lo_id;
    assign w_do_grant = w_found_lo & w_slot_free;
    assign w_gnt_rw   = req_rw[w_gnt_id];
    assign w_next_ptr = (int'(w_gnt_id) == NUM_REQ - 1) ? '0 : w_gnt_id + ID_W'(1);
    assign req_ready  = w_do_grant ? (c_ONE << w_gnt_id) : '0;

    assign w_push = w_do_grant & ~w_gnt_rw;
    assign w_pop  = MRA_rsp_valid & (r_cnt != '0);
    assign w_head = r_fifo[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr      <= '0;
            r_rw        <= 1'b0;
            r_valid     <= 1'b0;
            r_rr_ptr    <= '0;
            r_cnt       <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_do_grant) begin
                r_addr   <= w_addr_arr[w_gnt_id];
                r_rw     <= w_gnt_rw;
                r_valid  <= 1'b1;
                r_rr_ptr <= w_next_ptr;
            end else if (MRA_ready) begin
                r_valid <= 1'b0;
            end

            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);

            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase

            r_rsp_valid <= w_pop ? (c_ONE << w_head) : '0;
            if (w_pop) r_rsp_data <= MRA_rsp_data;
            if (MRA_rsp_valid && r_cnt == '0) r_rsp_err <= 1'b1;
        end
    end

    // ID storage needs no reset: the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= w_gnt_id;
    end

    assign MRA_req_addr   = r_addr;
    assign MRA_rw         = r_rw;
    assign MRA_req_valid  = r_valid;
    assign rd_outstanding = r_cnt;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_data       = r_rsp_data;
    assign rsp_err        = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_mra_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mra_arbiter
//   Directed self-checking bench for mra_arbiter (NUM_REQ=4, MAX_OUTSTANDING=8).
//   Revision: 1.0
// ============================================================================
module tb_mra_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int ADDR_WIDTH = 64;
    localparam int DATA_WIDTH = 64;
    localparam int MAX_OUT    = 8;
    localparam int CNT_W      = $clog2(MAX_OUT) + 1;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]            req_rw = '0;
    logic [NUM_REQ-1:0]            req_valid = '0;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic [ADDR_WIDTH-1:0]         MRA_req_addr;
    logic                          MRA_rw;
    logic                          MRA_req_valid;
    logic                          MRA_ready = 1'b0;
    logic                          MRA_rsp_valid = 1'b0;
    logic [DATA_WIDTH-1:0]         MRA_rsp_data = '0;
    logic [CNT_W-1:0]              rd_outstanding;
    logic                          rsp_err;

    int n_cmp = 0;
    int n_err = 0;

    mra_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .ADDR_WIDTH     (ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .MAX_OUTSTANDING(MAX_OUT)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .req_addr      (req_addr),
        .req_rw        (req_rw),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .MRA_req_addr  (MRA_req_addr),
        .MRA_rw        (MRA_rw),
        .MRA_req_valid (MRA_req_valid),
        .MRA_ready     (MRA_ready),
        .MRA_rsp_valid (MRA_rsp_valid),
        .MRA_rsp_data  (MRA_rsp_data),
        .rd_outstanding(rd_outstanding),
        .rsp_err       (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid     = '0;
        req_rw        = '0;
        MRA_ready     = 1'b0;
        MRA_rsp_valid = 1'b0;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_mra_valid", MRA_req_valid, 0);
        check("rst_mra_addr", MRA_req_addr, 0);
        check("rst_outstanding", rd_outstanding, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        step();

        // Single read from requester 2
        req_addr = '0;
        req_addr[2*ADDR_WIDTH +: ADDR_WIDTH] = 64'h1000;
        req_valid = 4'b0100;
        req_rw    = 4'b0000;
        MRA_ready = 1'b1;
        @(negedge clk);
        check("single_grant", req_ready, 4'b0100);
        step();
        req_valid = '0;
        @(negedge clk);
        check("single_mra_valid", MRA_req_valid, 1);
        check("single_mra_addr", MRA_req_addr, 64'h1000);
        check("single_mra_rw", MRA_rw, 0);
        check("single_out_1", rd_outstanding, 1);
        step();
        @(negedge clk);
        check("single_mra_clear", MRA_req_valid, 0);
        MRA_rsp_valid = 1'b1;
        MRA_rsp_data  = 64'hABCD;
        check("single_rsp_not_yet", rsp_valid, 0);
        step();
        MRA_rsp_valid = 1'b0;
        @(negedge clk);
        check("single_rsp_valid", rsp_valid, 4'b0100);
        check("single_rsp_data", rsp_data, 64'hABCD);
        check("single_out_0", rd_outstanding, 0);
        step();

        // Fairness: continuous writes from all requesters
        do_reset();
        req_valid = 4'hF;
        req_rw    = 4'hF;
        MRA_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("fair_%0d", k), req_ready, 64'd1 << (k % 4));
            step();
        end
        req_valid = '0;

        // Backpressure
        do_reset();
        for (int i = 0; i < NUM_REQ; i++)
            req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = 64'h100 * (i + 1);
        req_valid = 4'b0001;
        req_rw    = 4'b0011;
        MRA_ready = 1'b1;
        @(negedge clk);
        check("bp_grant0", req_ready, 4'b0001);
        step();
        MRA_ready = 1'b0;
        req_valid = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_ready_%0d", k), req_ready, 0);
            check($sformatf("bp_addr_%0d", k), MRA_req_addr, 64'h100);
            check($sformatf("bp_valid_%0d", k), MRA_req_valid, 1);
            check($sformatf("bp_rw_%0d", k), MRA_rw, 1);
            step();
        end
        MRA_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", req_ready, 4'b0010);
        step();
        req_valid = '0;
        @(negedge clk);
        check("bp_new_addr", MRA_req_addr, 64'h200);
        step();

        // Outstanding limit
        do_reset();
        req_valid = 4'b0001;
        req_rw    = 4'b0000;
        MRA_ready = 1'b1;
        for (int k = 0; k < MAX_OUT; k++) begin
            @(negedge clk);
            check($sformatf("lim_grant_%0d", k), req_ready, 4'b0001);
            step();
        end
        @(negedge clk);
        check("lim_count_full", rd_outstanding, MAX_OUT);
        check("lim_read_blocked", req_ready, 0);
        req_valid = 4'b0011;
        req_rw    = 4'b0010;
        #1;
        check("lim_write_granted", req_ready, 4'b0010);
        step();
        req_valid = 4'b0001;
        req_rw    = 4'b0000;
        @(negedge clk);
        check("lim_count_after_wr", rd_outstanding, MAX_OUT);
        check("lim_wr_issued", MRA_rw, 1);
        MRA_rsp_valid = 1'b1;
        MRA_rsp_data  = 64'h55;
        #1;
        check("lim_blocked_during_pop", req_ready, 0);
        step();
        MRA_rsp_valid = 1'b0;
        @(negedge clk);
        check("lim_count_7", rd_outstanding, MAX_OUT - 1);
        check("lim_reenabled", req_ready, 4'b0001);
        check("lim_rsp_route", rsp_valid, 4'b0001);
        step();
        req_valid = '0;

        // Response routing: reads from 3, 1, 3
        do_reset();
        MRA_ready = 1'b1;
        req_rw    = '0;
        req_valid = 4'b1000;
        @(negedge clk);
        check("route_g3a", req_ready, 4'b1000);
        step();
        req_valid = 4'b0010;
        @(negedge clk);
        check("route_g1", req_ready, 4'b0010);
        step();
        req_valid = 4'b1000;
        @(negedge clk);
        check("route_g3b", req_ready, 4'b1000);
        step();
        req_valid = '0;
        @(negedge clk);
        check("route_out_3", rd_outstanding, 3);
        step();
        MRA_rsp_valid = 1'b1;
        MRA_rsp_data  = 64'h11;
        step();
        MRA_rsp_data  = 64'h22;
        @(negedge clk);
        check("route_rsp0", rsp_valid, 4'b1000);
        check("route_dat0", rsp_data, 64'h11);
        step();
        MRA_rsp_data  = 64'h33;
        @(negedge clk);
        check("route_rsp1", rsp_valid, 4'b0010);
        check("route_dat1", rsp_data, 64'h22);
        step();
        MRA_rsp_valid = 1'b0;
        @(negedge clk);
        check("route_rsp2", rsp_valid, 4'b1000);
        check("route_dat2", rsp_data, 64'h33);
        check("route_out_0", rd_outstanding, 0);
        step();

        // Unexpected response
        MRA_rsp_valid = 1'b1;
        MRA_rsp_data  = 64'hDEAD;
        step();
        MRA_rsp_valid = 1'b0;
        @(negedge clk);
        check("err_set", rsp_err, 1);
        check("err_no_rsp", rsp_valid, 0);
        check("err_no_count", rd_outstanding, 0);
        step();
        step();
        @(negedge clk);
        check("err_sticky", rsp_err, 1);
        step();

        // Reset mid-burst
        req_valid = 4'hF;
        req_rw    = 4'h0;
        MRA_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("burst_out_3", rd_outstanding, 3);
        check("burst_valid", MRA_req_valid, 1);
        rst       = 1'b1;
        req_valid = '0;
        #1;
        check("arst_valid", MRA_req_valid, 0);
        check("arst_addr", MRA_req_addr, 0);
        check("arst_out", rd_outstanding, 0);
        check("arst_err", rsp_err, 0);
        check("arst_ready", req_ready, 0);
        step();
        rst = 1'b0;
        MRA_rsp_valid = 1'b1;
        step();
        MRA_rsp_valid = 1'b0;
        @(negedge clk);
        check("post_rst_err", rsp_err, 1);
        check("post_rst_no_rsp", rsp_valid, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mra_arbiter.md
# mra_arbiter

Shares a single MRA request port among NUM_REQ independent requesters, e.g. several per-tile MRA controllers. Arbitration is round-robin. The block registers the granted request toward the MRA and holds it stable under backpressure. It tracks the requester ID of every in-flight read so that in-order MRA read responses are routed back to the issuing requester. It sits between the requester-side controllers and the MRA, one clock domain.

## Interface
- NUM_REQ, 4: number of requesters (2..8).
- ADDR_WIDTH, 64: request address width.
- DATA_WIDTH, 64: read response data width.
- MAX_OUTSTANDING, 8: maximum in-flight reads (power of 2, ≥2).
- ID_W, $clog2(NUM_REQ): derived requester-ID width.
- CNT_W, $clog2(MAX_OUTSTANDING)+1: derived outstanding-count width.

Ports:
- clk  in  1  Clock, rising edge.
- rst  in  1  Asynchronous, active-high reset.
- req_addr  in  NUM_REQ*ADDR_WIDTH  Per-requester address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_rw  in  NUM_REQ  Per-requester direction: 1 = write, 0 = read.
- req_valid  in  NUM_REQ  Per-requester request valid.
- req_ready  out  NUM_REQ  One-hot grant. A request transfers when req_valid[i] & req_ready[i].
- rsp_valid  out  NUM_REQ  One-hot read-response strobe.
- rsp_data  out  DATA_WIDTH  Read data, common to all requesters; qualified by rsp_valid.
- MRA_req_addr  out  ADDR_WIDTH  Registered request address.
- MRA_rw  out  1  Registered request direction.
- MRA_req_valid  out  1  Registered request valid.
- MRA_ready  in  1  MRA accepts the request when MRA_req_valid & MRA_ready.
- MRA_rsp_valid  in  1  Read response valid. Responses return in issue order.
- MRA_rsp_data  in  DATA_WIDTH  Read response data.
- rd_outstanding  out  CNT_W  Number of reads that are granted but not yet responded.
- rsp_err  out  1  Sticky flag. Set by a response that arrives with no read outstanding.

## Operation
- Output slot: one register holding {addr, rw, id} plus MRA_req_valid.
- The slot is free when MRA_req_valid=0, or when MRA_req_valid & MRA_ready in the current cycle.
- Eligibility: requester i is eligible when req_valid[i]=1 and either req_rw[i]=1 (write), or rd_outstanding < MAX_OUTSTANDING (read).
- Grant: when the slot is free, req_ready asserts one-hot for the first eligible requester, searching upward from rr_ptr with wrap-around. All req_ready bits are 0 when the slot is not free or no requester is eligible.
- req_ready is combinational from req_valid, req_rw, rr_ptr, rd_outstanding and MRA_ready.
- On a grant to requester g:
  - The slot loads requester g's request and MRA_req_valid=1.
  - rr_ptr becomes (g+1) mod NUM_REQ.
  - If the request is a read, g is pushed into the ID FIFO (depth MAX_OUTSTANDING) and rd_outstanding increments.
- rr_ptr does not change when there is no grant.
- If the slot is accepted by the MRA and no new grant occurs, MRA_req_valid clears.
- MRA_req_addr, MRA_rw and MRA_req_valid hold stable while MRA_req_valid=1 and MRA_ready=0.
- Response path, on MRA_rsp_valid with the FIFO non-empty:
  - The FIFO pops its head ID h.
  - rd_outstanding decrements.
  - Next cycle, rsp_valid has only bit h set and rsp_data = MRA_rsp_data.
- Unexpected response: MRA_rsp_valid with the FIFO empty sets rsp_err. The response is dropped: no rsp_valid, no counter change.
- Simultaneous push and pop: both occur and rd_outstanding is unchanged.
- A pop with the FIFO full frees a slot only in the following cycle; eligibility uses the registered count.
- rd_outstanding never exceeds MAX_OUTSTANDING or drops below 0.
- Writes are not tracked and produce no response.

## Timing
- Reset (asynchronous, immediate) clears: MRA_req_valid=0, MRA_req_addr=0, MRA_rw=0, rr_ptr=0, FIFO empty, rd_outstanding=0, rsp_valid=0, rsp_data=0, rsp_err=0. req_ready follows combinationally, so it is 0 whenever no requester is valid.
- Reset mid-operation discards all in-flight state. Responses that arrive after reset are treated as unexpected.
- Grant at edge N drives MRA_req_valid high in cycle N+1.
- Full throughput: with MRA_ready held at 1, one request issues per cycle.
- MRA_rsp_valid in cycle M produces rsp_valid in cycle M+1.
- rsp_err remains set until reset.

## Test plan
- Single read, NUM_REQ=4: requester 2 reads addr 0x1000; MRA_ready=1.
  - Required: req_ready=4'b0100 in the grant cycle, then MRA_req_addr=0x1000 and MRA_rw=0 for one cycle.
  - Then MRA_rsp_data=0xABCD produces rsp_valid=4'b0100 and rsp_data=0xABCD one cycle later. rd_outstanding goes 0→1→0.
- Fairness: all four requesters hold continuous writes with MRA_ready=1. Required grant order: 0,1,2,3,0,1, one grant per cycle.
- Backpressure: MRA_ready=0 for 5 cycles after a grant.
  - Required: MRA_req_* stable throughout and req_ready=0.
  - Releasing MRA_ready allows a new grant in that same cycle.
- Outstanding limit, MAX_OUTSTANDING=8: issue 8 reads with no responses.
  - Required: rd_outstanding=8; further reads are not granted, while a pending write is still granted.
  - One response re-enables read grants the next cycle.
- Response routing: reads issued by requesters 3, 1, 3, followed by three responses. Required rsp_valid sequence: 4'b1000, 4'b0010, 4'b1000.
- Error and reset:
  - MRA_rsp_valid with nothing outstanding sets rsp_err and produces no rsp_valid.
  - Asserting rst mid-burst immediately clears all outputs and rd_outstanding.
